// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control-store sequencer: field layout,
// COND encodings, reset microinstruction and sequencer FSM states.
package lc3_pkg;

   localparam int CS_ADDR_W           = 6;
   localparam int SEQ_W               = 10;
   localparam int IRD_BIT             = 9;
   localparam int COND_MSB            = 8;
   localparam int COND_LSB            = 6;
   localparam int J_MSB               = 5;
   localparam int J_LSB               = 0;
   localparam int J_W                 = J_MSB - J_LSB + 1;
   localparam int COND_W              = COND_MSB - COND_LSB + 1;
   localparam int RESET_STATE_DEFAULT = 18;

   localparam logic [COND_W-1:0] COND_NONE  = 3'b000;
   localparam logic [COND_W-1:0] COND_MEM_R = 3'b001;
   localparam logic [COND_W-1:0] COND_BEN   = 3'b010;
   localparam logic [COND_W-1:0] COND_ADDR  = 3'b011;
   localparam logic [COND_W-1:0] COND_PRIV  = 3'b100;
   localparam logic [COND_W-1:0] COND_INT   = 3'b101;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_PRIME = 2'd1,
      SEQ_RUN   = 2'd2
   } seq_state_t;

   function automatic logic [COND_W-1:0] seq_cond(input logic [SEQ_W-1:0] w);
      return w[COND_MSB:COND_LSB];
   endfunction

endpackage

// File: rtl/lc3_microsequencer_if.sv
// Bundle between the microsequencer and its control store / datapath:
// condition inputs and sequencing field in, control store read port out.
interface lc3_microsequencer_if
   import lc3_pkg::*;
#(
   parameter int AddrBusSize = CS_ADDR_W
);
   logic                   i_run;
   logic [SEQ_W-1:0]       i_ctrl_next;
   logic [3:0]             i_ir_opcode;
   logic                   i_ir11;
   logic                   i_ben;
   logic                   i_mem_ready;
   logic                   i_psr15;
   logic                   i_int;
   logic                   o_cs_read_en;
   logic [AddrBusSize-1:0] o_cs_read_addr;
   logic [AddrBusSize-1:0] o_state;
   logic                   o_uop_valid;
   logic                   o_mem_timeout;

   modport slave (
      input  i_run, i_ctrl_next, i_ir_opcode, i_ir11, i_ben, i_mem_ready, i_psr15, i_int,
      output o_cs_read_en, o_cs_read_addr, o_state, o_uop_valid, o_mem_timeout
   );

   modport master (
      output i_run, i_ctrl_next, i_ir_opcode, i_ir11, i_ben, i_mem_ready, i_psr15, i_int,
      input  o_cs_read_en, o_cs_read_addr, o_state, o_uop_valid, o_mem_timeout
   );
endinterface

// File: rtl/lc3_next_addr.sv
// Combinational next-microinstruction address: IRD opcode dispatch, otherwise
// J with one condition bit OR-ed in as selected by COND.
module lc3_next_addr
   import lc3_pkg::*;
#(
   parameter int AddrBusSize = CS_ADDR_W
) (
   input  logic [SEQ_W-1:0]       ctrl_next,
   input  logic [3:0]             ir_opcode,
   input  logic                   ir11,
   input  logic                   ben,
   input  logic                   mem_ready,
   input  logic                   psr15,
   input  logic                   int_pend,
   output logic [AddrBusSize-1:0] next_addr
);

   logic              ird;
   logic [COND_W-1:0] cond;
   logic [J_W-1:0]    j;
   logic [J_W-1:0]    j_mod;

   assign ird  = ctrl_next[IRD_BIT];
   assign cond = seq_cond(ctrl_next);
   assign j    = ctrl_next[J_MSB:J_LSB];

   always_comb begin
      j_mod = j;
      case (cond)
         COND_MEM_R: j_mod[1] = j[1] | mem_ready;
         COND_BEN:   j_mod[2] = j[2] | ben;
         COND_ADDR:  j_mod[0] = j[0] | ir11;
         COND_PRIV:  j_mod[3] = j[3] | psr15;
         COND_INT:   j_mod[4] = j[4] | int_pend;
         default:    j_mod    = j;
      endcase
   end

   // Opcode dispatch overrides any COND branch in the same word.
   always_comb begin
      if (ird) next_addr = AddrBusSize'({2'b00, ir_opcode});
      else     next_addr = AddrBusSize'(j_mod);
   end

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: primes the registered control store after reset,
// advances one microinstruction per running cycle and flags long memory waits.
module lc3_microsequencer
   import lc3_pkg::*;
#(
   parameter int AddrBusSize = CS_ADDR_W,
   parameter int RESET_STATE = RESET_STATE_DEFAULT,
   parameter int MEM_TIMEOUT = 255
) (
   input logic                 i_CLK,
   input logic                 i_RST_N,
   lc3_microsequencer_if.slave bus
);

   localparam int                     CNT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [AddrBusSize-1:0] RESET_ADDR = AddrBusSize'(RESET_STATE);
   localparam logic [CNT_W-1:0]       CNT_MAX    = CNT_W'(MEM_TIMEOUT);

   seq_state_t             seq_q;
   seq_state_t             seq_d;
   logic [AddrBusSize-1:0] state_q;
   logic [AddrBusSize-1:0] next_addr;
   logic [CNT_W-1:0]       wait_cnt_q;
   logic [CNT_W-1:0]       wait_cnt_d;
   logic                   timeout_q;
   logic                   read_en;
   logic [AddrBusSize-1:0] read_addr;
   logic                   uop_valid;
   logic                   ird;
   logic [COND_W-1:0]      cond;
   logic                   mem_wait;

   lc3_next_addr #(
      .AddrBusSize(AddrBusSize)
   ) u_next_addr (
      .ctrl_next (bus.i_ctrl_next),
      .ir_opcode (bus.i_ir_opcode),
      .ir11      (bus.i_ir11),
      .ben       (bus.i_ben),
      .mem_ready (bus.i_mem_ready),
      .psr15     (bus.i_psr15),
      .int_pend  (bus.i_int),
      .next_addr (next_addr)
   );

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) seq_q <= SEQ_IDLE;
      else          seq_q <= seq_d;
   end

   always_comb begin
      seq_d = seq_q;
      case (seq_q)
         SEQ_IDLE:  if (bus.i_run) seq_d = SEQ_PRIME;
         SEQ_PRIME: seq_d = SEQ_RUN;
         SEQ_RUN:   seq_d = SEQ_RUN;
         default:   seq_d = SEQ_IDLE;
      endcase
   end

   // PRIME fetches the reset word so it is on the store output when RUN begins.
   always_comb begin
      read_en   = 1'b0;
      read_addr = RESET_ADDR;
      uop_valid = 1'b0;
      case (seq_q)
         SEQ_PRIME: read_en = 1'b1;
         SEQ_RUN: begin
            read_en   = bus.i_run;
            read_addr = next_addr;
            uop_valid = bus.i_run;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N)                          state_q <= RESET_ADDR;
      else if (seq_q == SEQ_PRIME)           state_q <= RESET_ADDR;
      else if (seq_q == SEQ_RUN && bus.i_run) state_q <= next_addr;
   end

   assign ird      = bus.i_ctrl_next[IRD_BIT];
   assign cond     = seq_cond(bus.i_ctrl_next);
   assign mem_wait = !ird && (cond == COND_MEM_R) && !bus.i_mem_ready;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (uop_valid) begin
         if (!mem_wait)                 wait_cnt_d = '0;
         else if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // The flag is sticky; only reset clears it, sequencing never looks at it.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         if (uop_valid && wait_cnt_d == CNT_MAX) timeout_q <= 1'b1;
      end
   end

   assign bus.o_cs_read_en   = read_en;
   assign bus.o_cs_read_addr = read_addr;
   assign bus.o_uop_valid    = uop_valid;
   assign bus.o_state        = state_q;
   assign bus.o_mem_timeout  = timeout_q;

endmodule

// File: doc/lc3_microsequencer.md
# lc3_microsequencer

LC-3 microsequencer that sequences the 64-entry, 52-bit control store. It computes the next microinstruction address from the 10 sequencing bits of the current microinstruction (IRD, COND, J) plus the datapath condition inputs. It drives the control store's synchronous read port and qualifies each microinstruction for the datapath. It also primes the registered control store output after reset, supports run/pause, and flags memory-ready timeouts.

## Interface
- AddrBusSize, 6, control store address width / FSM state number width
- RESET_STATE, 18, first microinstruction fetched after reset
- MEM_TIMEOUT, 255, consecutive memory-wait cycles before the timeout flag sets
- i_CLK  in  1  single clock, rising edge
- i_RST_N  in  1  reset, asynchronous assert, active-low
- i_run  in  1  1 = execute/advance; 0 = hold the current microinstruction
- i_ctrl_next  in  10  sequencing field of the current control store word: [9] IRD, [8:6] COND, [5:0] J
- i_ir_opcode  in  4  IR[15:12]
- i_ir11  in  1  IR[11]
- i_ben  in  1  branch enable
- i_mem_ready  in  1  memory R signal
- i_psr15  in  1  PSR[15] (user mode)
- i_int  in  1  pending interrupt
- o_cs_read_en  out  1  control store read enable
- o_cs_read_addr  out  AddrBusSize  control store read address
- o_state  out  AddrBusSize  number of the microinstruction currently on the control store output
- o_uop_valid  out  1  datapath may act on the control store output this cycle
- o_mem_timeout  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT

## Operation
- The sequencer FSM has three states: IDLE, PRIME, RUN.
- IDLE (reset state):
  - o_cs_read_en = 0, o_uop_valid = 0, o_cs_read_addr = RESET_STATE.
  - When i_run = 1, go to PRIME.
- PRIME:
  - o_cs_read_en = 1, o_cs_read_addr = RESET_STATE, o_uop_valid = 0.
  - Unconditionally go to RUN and load o_state <= RESET_STATE. i_run is ignored in this state.
- RUN:
  - o_uop_valid = i_run, o_cs_read_en = i_run, o_cs_read_addr = next address.
  - When i_run = 1: o_state <= next address.
  - When i_run = 0: o_state holds and there is no read, so the control store output keeps the current word.
- Next address (combinational):
  - IRD = 1: {2'b00, i_ir_opcode}.
  - Otherwise J with OR-in by COND:
    - 001: J[1] |= i_mem_ready
    - 010: J[2] |= i_ben
    - 011: J[0] |= i_ir11
    - 100: J[3] |= i_psr15
    - 101: J[4] |= i_int
    - 000/110/111: J unchanged.
  - IRD has priority over COND.
- Timeout counter:
  - Width $clog2(MEM_TIMEOUT+1), saturating.
  - Increments on each cycle with o_uop_valid, IRD = 0, COND = 001 and i_mem_ready = 0.
  - Clears on any valid cycle that does not meet that condition. Holds while i_run = 0.
  - o_mem_timeout sets when the counter reaches MEM_TIMEOUT and stays set until reset. Sequencing is not altered.
- Reset values: FSM = IDLE, o_state = RESET_STATE, counter = 0, o_mem_timeout = 0.
- Reset asserted mid-operation returns to IDLE immediately; a fresh PRIME is required.

## Timing
- Control store read latency is 1 cycle: an address issued at edge t appears on the control store output after edge t+1, matching o_state.
- Throughput in RUN with i_run = 1 is one microinstruction per cycle.
- The next address depends combinationally on the control store output and the condition inputs. There is no registered stage between them.
- The first o_uop_valid occurs 2 cycles after i_run rises in IDLE.
- Pause/resume costs zero cycles and does not re-prime.
- Memory-wait self-loops (e.g. state 33 → 33 until R) are expressed purely through J/COND. The sequencer itself adds no stall.

## Structure
- A shared package `lc3_pkg` holds:
  - COND encodings (COND_NONE, COND_MEM_R, COND_BEN, COND_ADDR, COND_PRIV, COND_INT)
  - sequencing field bit positions
  - the RESET_STATE default
  - the sequencer FSM state enum.
- One natural sub-module, `lc3_next_addr`: purely combinational next-address logic (IRD/COND/J OR-in). The FSM, state register and timeout counter stay in the top module.

## Test plan
- Reset, then i_run = 1 → cycle 1: read_en = 1, addr = 18, valid = 0; cycle 2: valid = 1, o_state = 18.
- IRD = 1, i_ir_opcode = 4'b0001 → o_cs_read_addr = 1. With IRD = 1, COND = 010, J = 6'b000000, ben = 1 → address 1 (IRD wins).
- COND = 010, J = 6'b000000, ben = 1 → addr 4. COND = 011, J = 6'b010100, ir11 = 1 → addr 21. COND = 001, J = 6'b100001, R = 0 → addr 33 (loop); R = 1 → addr 35.
- i_run held 0 for 3 cycles in RUN → read_en = 0, valid = 0, o_state unchanged. Control store output word unchanged on resume; the next cycle advances normally.
- MEM_TIMEOUT = 4, state 33 self-loop with R = 0 → o_mem_timeout rises after the 4th wait cycle and remains 1 after R = 1. Only reset clears it.
- Reset asserted while in RUN at o_state = 33 → outputs immediately return to IDLE values. After release, the full prime sequence is required again.
